// File: rtl/temporal_ngram_encoder_pkg.sv
// Purpose   : shared constants, FSM state type and sizing helper for the temporal N-gram encoder.
// Latency   : n/a (declarations only).
// Backpressure: n/a.
package temporal_ngram_encoder_pkg;

    // Default build: hypervector width and number of time samples bound per N-gram (1..16).
    localparam int HV_DIMENSION_DEF = 2000;
    localparam int NGRAM_SIZE_DEF   = 4;

    typedef enum logic {
        ST_IDLE      = 1'b0,
        ST_OUT_VALID = 1'b1
    } state_e;

    // Smallest r with 2**r >= value; returns 0 for value <= 1.
    function automatic int ceil_log2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/temporal_ngram_encoder_hv_history_buffer.sv
// Purpose   : shift register of past hypervectors; tap k holds the vector accepted k+1 samples ago.
// Latency   : taps update one edge after shift_en_i; clear_i zeroes all taps at the next edge.
// Backpressure: none; shifts whenever shift_en_i is high.
// Ports: core_clk/rst_n (sync, active-low), shift_en_i, clear_i, din_i, taps_o (tap k at [k*WIDTH +: WIDTH]).
module hv_history_buffer
    import temporal_ngram_encoder_pkg::*;
#(
    parameter  int WIDTH  = 8,
    parameter  int DEPTH  = 1,
    localparam int TAPS_W = (DEPTH > 0 ? DEPTH : 1) * WIDTH
) (
    input  logic              core_clk,
    input  logic              rst_n,
    input  logic              shift_en_i,
    input  logic              clear_i,
    input  logic [WIDTH-1:0]  din_i,
    output logic [TAPS_W-1:0] taps_o
);

    if (DEPTH == 0) begin : g_empty
        // A 1-gram needs no history; the port bus is kept one vector wide and tied off.
        logic unused_inputs;
        assign unused_inputs = ^{core_clk, rst_n, shift_en_i, clear_i, din_i};
        assign taps_o        = '0;
    end else begin : g_shift
        logic [WIDTH-1:0] hist_q [DEPTH];
        logic [WIDTH-1:0] hist_d [DEPTH];

        // Clear takes effect before the shift, so a simultaneous clear and shift
        // leaves din_i as the only live sample of the new window.
        always_comb begin
            for (int k = 0; k < DEPTH; k++) begin
                hist_d[k] = clear_i ? '0 : hist_q[k];
            end
            if (shift_en_i) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    hist_d[k] = clear_i ? '0 : hist_q[k-1];
                end
                hist_d[0] = din_i;
            end
        end

        always_ff @(posedge core_clk) begin
            if (!rst_n) begin
                for (int k = 0; k < DEPTH; k++) begin
                    hist_q[k] <= '0;
                end
            end else begin
                for (int k = 0; k < DEPTH; k++) begin
                    hist_q[k] <= hist_d[k];
                end
            end
        end

        for (genvar k = 0; k < DEPTH; k++) begin : g_tap
            assign taps_o[k*WIDTH +: WIDTH] = hist_q[k];
        end
    end

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Purpose   : binds the newest NGRAM_SIZE spatial hypervectors into one N-gram (XOR of rotated samples).
// Latency   : sample accepted at edge t gives ValidOut_SO/NgramOut_DO from edge t+1; at most one N-gram per 2 cycles.
// Backpressure: ReadyOut_SO drops while an N-gram waits for ReadyIn_SI; no input is taken in the handoff cycle.
// Ports: Clk_CI, Reset_RBI (sync, active-low), ValidIn_SI/ReadyOut_SO/HypervectorIn_DI (upstream),
//        ClearHistory_SI (new-window pulse), ValidOut_SO/ReadyIn_SI/NgramOut_DO (downstream). Bit 0 is the MSB.
module temporal_ngram_encoder
    import temporal_ngram_encoder_pkg::*;
#(
    parameter int HV_DIMENSION = HV_DIMENSION_DEF,
    parameter int NGRAM_SIZE   = NGRAM_SIZE_DEF
) (
    input  logic                    Clk_CI,
    input  logic                    Reset_RBI,
    input  logic                    ValidIn_SI,
    output logic                    ReadyOut_SO,
    input  logic [0:HV_DIMENSION-1] HypervectorIn_DI,
    input  logic                    ClearHistory_SI,
    output logic                    ValidOut_SO,
    input  logic                    ReadyIn_SI,
    output logic [0:HV_DIMENSION-1] NgramOut_DO
);

    localparam int HIST_DEPTH = NGRAM_SIZE - 1;
    localparam int TAPS_W     = (HIST_DEPTH > 0 ? HIST_DEPTH : 1) * HV_DIMENSION;
    localparam int FILL_W     = ceil_log2(NGRAM_SIZE) + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(HIST_DEPTH);

    // Internal vectors are descending, so port bit 0 maps to the MSB and a
    // rotate right is a plain {low bits, high bits} concatenation.
    logic [HV_DIMENSION-1:0] hv_in;
    logic [TAPS_W-1:0]       taps;
    logic [HV_DIMENSION-1:0] xor_acc [NGRAM_SIZE];
    logic [HV_DIMENSION-1:0] ngram_comb;

    state_e                  state_q, state_d;
    logic [FILL_W-1:0]       fill_q, fill_d, fill_base;
    logic [HV_DIMENSION-1:0] ngram_q, ngram_d;
    logic                    ready_q, ready_d;
    logic                    valid_q, valid_d;
    logic                    accept;

    assign hv_in = HypervectorIn_DI;

    hv_history_buffer #(
        .WIDTH (HV_DIMENSION),
        .DEPTH (HIST_DEPTH)
    ) u_history (
        .core_clk   (Clk_CI),
        .rst_n      (Reset_RBI),
        .shift_en_i (accept),
        .clear_i    (ClearHistory_SI),
        .din_i      (hv_in),
        .taps_o     (taps)
    );

    // Tap k-1 holds H(k); it is rotated right by k before joining the XOR chain.
    assign xor_acc[0] = hv_in;
    for (genvar k = 1; k < NGRAM_SIZE; k++) begin : g_bind
        logic [HV_DIMENSION-1:0] tap_hv;
        assign tap_hv     = taps[(k-1)*HV_DIMENSION +: HV_DIMENSION];
        assign xor_acc[k] = xor_acc[k-1] ^ {tap_hv[k-1:0], tap_hv[HV_DIMENSION-1:k]};
    end
    assign ngram_comb = xor_acc[NGRAM_SIZE-1];

    if (HIST_DEPTH == 0) begin : g_no_taps
        logic unused_taps;
        assign unused_taps = ^taps;
    end

    always_comb begin
        // A clear pulse restarts the window before any same-cycle input is counted.
        fill_base = ClearHistory_SI ? '0 : fill_q;
        accept    = ready_q && ValidIn_SI;
        state_d   = state_q;
        fill_d    = fill_base;
        ngram_d   = ngram_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                // ready_q is still low on the first cycle after reset release.
                ready_d = 1'b1;
                valid_d = 1'b0;
                if (accept) begin
                    if (fill_base == FILL_FULL) begin
                        ngram_d = ngram_comb;
                        state_d = ST_OUT_VALID;
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                    end else begin
                        fill_d = fill_base + FILL_W'(1);
                    end
                end
            end
            ST_OUT_VALID: begin
                if (ReadyIn_SI) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                    valid_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            ngram_q <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ngram_q <= ngram_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
        end
    end

    assign ReadyOut_SO = ready_q;
    assign ValidOut_SO = valid_q;
    assign NgramOut_DO = ngram_q;

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Purpose   : self-checking bench for temporal_ngram_encoder (8-bit vectors, 3-gram and 1-gram builds).
// Latency   : n/a.
// Backpressure: n/a.
module tb_temporal_ngram_encoder;

    localparam int W = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;

    logic         in_vld = 1'b0, in_clr = 1'b0, in_rdy = 1'b0;
    logic [W-1:0] in_dat = '0;
    logic         out_rdy, out_vld;
    logic [W-1:0] out_dat;

    logic         v1_vld = 1'b0, v1_clr = 1'b0, v1_rdy = 1'b1;
    logic [W-1:0] v1_dat = '0;
    logic         o1_rdy, o1_vld;
    logic [W-1:0] o1_dat;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    temporal_ngram_encoder #(.HV_DIMENSION(W), .NGRAM_SIZE(N)) dut (
        .Clk_CI           (clk),
        .Reset_RBI        (rst_n),
        .ValidIn_SI       (in_vld),
        .ReadyOut_SO      (out_rdy),
        .HypervectorIn_DI (in_dat),
        .ClearHistory_SI  (in_clr),
        .ValidOut_SO      (out_vld),
        .ReadyIn_SI       (in_rdy),
        .NgramOut_DO      (out_dat)
    );

    temporal_ngram_encoder #(.HV_DIMENSION(W), .NGRAM_SIZE(1)) dut1 (
        .Clk_CI           (clk),
        .Reset_RBI        (rst_n),
        .ValidIn_SI       (v1_vld),
        .ReadyOut_SO      (o1_rdy),
        .HypervectorIn_DI (v1_dat),
        .ClearHistory_SI  (v1_clr),
        .ValidOut_SO      (o1_vld),
        .ReadyIn_SI       (v1_rdy),
        .NgramOut_DO      (o1_dat)
    );

    // Reference model: a list of past samples (newest first) and the handshake state.
    logic         m_rdy = 1'b0, m_vld = 1'b0;
    logic [W-1:0] m_dat = '0;
    logic [W-1:0] m_hist [$];

    function automatic logic [W-1:0] rot(input logic [W-1:0] x, input int k);
        logic [W-1:0] r;
        r = x;
        for (int i = 0; i < k; i++) begin
            r = (r >> 1) | (r << (W - 1));
        end
        return r;
    endfunction

    task automatic model_edge();
        logic [W-1:0] nv;
        if (!rst_n) begin
            m_rdy = 1'b0;
            m_vld = 1'b0;
            m_dat = '0;
            m_hist.delete();
        end else begin
            if (in_clr) m_hist.delete();
            if (m_rdy && in_vld) begin
                if (m_hist.size() == N - 1) begin
                    nv = in_dat;
                    for (int k = 1; k < N; k++) nv = nv ^ rot(m_hist[k-1], k);
                    m_dat = nv;
                    m_vld = 1'b1;
                    m_rdy = 1'b0;
                end else begin
                    m_rdy = 1'b1;
                end
                m_hist.push_front(in_dat);
                if (m_hist.size() > N - 1) m_hist.pop_back();
            end else if (m_vld) begin
                if (in_rdy) begin
                    m_vld = 1'b0;
                    m_rdy = 1'b1;
                end
            end else begin
                m_rdy = 1'b1;
            end
        end
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic         vld;
        logic         clr;
        logic         rdy;
        logic [W-1:0] dat;
        logic         e_rdy;
        logic         e_vld;
        logic [W-1:0] e_dat;
    } vec_t;

    vec_t tbl [$];

    task automatic add(input logic v, input logic c, input logic r, input logic [W-1:0] d,
                       input logic er, input logic ev, input logic [W-1:0] ed);
        vec_t t;
        t.vld = v; t.clr = c; t.rdy = r; t.dat = d;
        t.e_rdy = er; t.e_vld = ev; t.e_dat = ed;
        tbl.push_back(t);
    endtask

    initial begin
        // Window fill, sliding window, backpressure, clear collision, clear while pending.
        add(1, 0, 0, 8'h80, 1, 0, 8'h00);
        add(1, 0, 0, 8'h01, 1, 0, 8'h00);
        add(1, 0, 0, 8'h0F, 0, 1, 8'hAF);
        add(0, 0, 1, 8'h00, 1, 0, 8'h00);
        add(1, 0, 0, 8'h00, 0, 1, 8'hC7);
        for (int i = 0; i < 5; i++) add(1, 0, 0, 8'h33, 0, 1, 8'hC7);
        add(1, 0, 1, 8'h33, 1, 0, 8'h00);
        add(1, 0, 0, 8'h33, 0, 1, 8'hF0);
        add(0, 0, 1, 8'h00, 1, 0, 8'h00);
        add(1, 1, 0, 8'hFF, 1, 0, 8'h00);
        add(1, 0, 0, 8'h12, 1, 0, 8'h00);
        add(1, 0, 0, 8'h34, 0, 1, 8'hC2);
        add(0, 0, 1, 8'h00, 1, 0, 8'h00);
        add(1, 0, 0, 8'h11, 0, 1, 8'h8F);
        add(0, 1, 0, 8'h00, 0, 1, 8'h8F);
        add(0, 0, 1, 8'h00, 1, 0, 8'h00);
        add(1, 0, 0, 8'h55, 1, 0, 8'h00);
        add(1, 0, 0, 8'h66, 1, 0, 8'h00);
        add(1, 0, 0, 8'h77, 0, 1, 8'h11);
        add(0, 0, 1, 8'h00, 1, 0, 8'h00);

        // Reset held two cycles with an input offered.
        rst_n = 1'b0; in_vld = 1'b1; in_dat = 8'hAA; v1_vld = 1'b1; v1_dat = 8'hAA;
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("reset_ready", 8'(out_rdy), 8'h00);
            check("reset_valid", 8'(out_vld), 8'h00);
            check("reset_data", out_dat, 8'h00);
            check("reset_valid_n1", 8'(o1_vld), 8'h00);
        end
        rst_n = 1'b1; in_vld = 1'b0; v1_vld = 1'b0;
        cycle();
        check("release_ready", 8'(out_rdy), 8'h01);
        check("release_ready_n1", 8'(o1_rdy), 8'h01);

        foreach (tbl[i]) begin
            in_vld = tbl[i].vld; in_clr = tbl[i].clr; in_rdy = tbl[i].rdy; in_dat = tbl[i].dat;
            cycle();
            check($sformatf("vec%0d_ready", i), 8'(out_rdy), 8'(tbl[i].e_rdy));
            check($sformatf("vec%0d_valid", i), 8'(out_vld), 8'(tbl[i].e_vld));
            if (tbl[i].e_vld) check($sformatf("vec%0d_data", i), out_dat, tbl[i].e_dat);
        end

        // Reset while an N-gram is pending discards it and the history.
        in_vld = 1'b1; in_clr = 1'b0; in_rdy = 1'b0; in_dat = 8'h99;
        cycle();
        check("pre_reset_valid", 8'(out_vld), 8'h01);
        rst_n = 1'b0; in_vld = 1'b0;
        cycle();
        check("midreset_valid", 8'(out_vld), 8'h00);
        check("midreset_data", out_dat, 8'h00);
        rst_n = 1'b1;
        cycle();
        check("midreset_release_ready", 8'(out_rdy), 8'h01);
        in_vld = 1'b1; in_dat = 8'h01;
        cycle();
        check("refill1_valid", 8'(out_vld), 8'h00);
        in_dat = 8'h02;
        cycle();
        check("refill2_valid", 8'(out_vld), 8'h00);
        in_dat = 8'h03;
        cycle();
        check("refill3_valid", 8'(out_vld), 8'h01);
        check("refill3_data", out_dat, 8'h42);
        in_vld = 1'b0; in_rdy = 1'b1;
        cycle();

        // 1-gram build: input passes straight through, one cycle later.
        v1_vld = 1'b1; v1_dat = 8'h5A; v1_rdy = 1'b0;
        cycle();
        check("n1_valid", 8'(o1_vld), 8'h01);
        check("n1_data", o1_dat, 8'h5A);
        check("n1_ready", 8'(o1_rdy), 8'h00);
        v1_vld = 1'b0; v1_rdy = 1'b1;
        cycle();
        check("n1_handoff_valid", 8'(o1_vld), 8'h00);
        check("n1_handoff_ready", 8'(o1_rdy), 8'h01);
        for (int i = 0; i < 4; i++) begin
            logic [W-1:0] d;
            d = 8'($urandom);
            v1_vld = 1'b1; v1_dat = d; v1_clr = 1'($urandom_range(0, 1)); v1_rdy = 1'b0;
            cycle();
            check("n1_rand_data", o1_dat, d);
            v1_vld = 1'b0; v1_clr = 1'b0; v1_rdy = 1'b1;
            cycle();
        end

        // Randomized traffic against the reference model.
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            in_vld = ($urandom % 4) != 0;
            in_clr = ($urandom % 16) == 0;
            in_rdy = ($urandom % 3) != 0;
            in_dat = 8'($urandom);
            rst_n  = ($urandom % 200) != 0;
            cycle();
            check("rand_ready", 8'(out_rdy), 8'(m_rdy));
            check("rand_valid", 8'(out_vld), 8'(m_vld));
            if (m_vld || !rst_n) check("rand_data", out_dat, m_dat);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
